// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, control-line, flag-index and FSM definitions for the ALU2 control path.
// CTRL_* values are ctrl_o[5:0] (bit i = Ctrl i); opcode table strings read Ctrl0 first.
package alu_ctrl_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CTRL_W  = 6;
  localparam int unsigned OP_W    = 4;

  localparam logic [OP_W-1:0] OP_MOV = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT = 4'h6;
  localparam logic [OP_W-1:0] OP_INC = 4'h7;
  localparam logic [OP_W-1:0] OP_DEC = 4'h8;
  localparam logic [OP_W-1:0] OP_SLA = 4'h9;
  localparam logic [OP_W-1:0] OP_SLL = 4'hA;
  localparam logic [OP_W-1:0] OP_ROL = 4'hB;
  localparam logic [OP_W-1:0] OP_SRA = 4'hC;
  localparam logic [OP_W-1:0] OP_SRL = 4'hD;
  localparam logic [OP_W-1:0] OP_ROR = 4'hE;
  localparam logic [OP_W-1:0] OP_ILL = 4'hF;

  localparam logic [CTRL_W-1:0] CTRL_MOV = 6'b000000;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 6'b010010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 6'b100010;
  localparam logic [CTRL_W-1:0] CTRL_AND = 6'b011000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 6'b010100;
  localparam logic [CTRL_W-1:0] CTRL_XOR = 6'b011100;
  localparam logic [CTRL_W-1:0] CTRL_NOT = 6'b001100;
  localparam logic [CTRL_W-1:0] CTRL_INC = 6'b110110;
  localparam logic [CTRL_W-1:0] CTRL_DEC = 6'b000110;
  localparam logic [CTRL_W-1:0] CTRL_SLA = 6'b001001;
  localparam logic [CTRL_W-1:0] CTRL_SLL = 6'b000001;
  localparam logic [CTRL_W-1:0] CTRL_ROL = 6'b010001;
  localparam logic [CTRL_W-1:0] CTRL_SRA = 6'b001101;
  localparam logic [CTRL_W-1:0] CTRL_SRL = 6'b000101;
  localparam logic [CTRL_W-1:0] CTRL_ROR = 6'b010101;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_S = 2;
  localparam int unsigned FLG_V = 3;

  localparam logic [FLAGS_W-1:0] MASK_ARITH = 4'b1111;
  localparam logic [FLAGS_W-1:0] MASK_LOGIC = 4'b0110;
  localparam logic [FLAGS_W-1:0] MASK_SHIFT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Logic ops force V to zero rather than sampling it from the ALU.
  function automatic logic op_clears_v(input logic [OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_op_encode.sv
// Combinational opcode decode: control lines, op class and which flags the ALU result may write.
module alu_op_encode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [5:0] ctrl_o,
  output logic       is_shift_o,
  output logic       is_illegal_o,
  output logic [3:0] flag_mask_o
);

  always_comb begin
    ctrl_o       = CTRL_MOV;
    is_shift_o   = 1'b0;
    is_illegal_o = 1'b0;
    flag_mask_o  = '0;
    case (op_i)
      OP_MOV: ctrl_o = CTRL_MOV;
      OP_ADD: begin ctrl_o = CTRL_ADD; flag_mask_o = MASK_ARITH; end
      OP_SUB: begin ctrl_o = CTRL_SUB; flag_mask_o = MASK_ARITH; end
      OP_AND: begin ctrl_o = CTRL_AND; flag_mask_o = MASK_LOGIC; end
      OP_OR:  begin ctrl_o = CTRL_OR;  flag_mask_o = MASK_LOGIC; end
      OP_XOR: begin ctrl_o = CTRL_XOR; flag_mask_o = MASK_LOGIC; end
      OP_NOT: begin ctrl_o = CTRL_NOT; flag_mask_o = MASK_LOGIC; end
      OP_INC: begin ctrl_o = CTRL_INC; flag_mask_o = MASK_ARITH; end
      OP_DEC: begin ctrl_o = CTRL_DEC; flag_mask_o = MASK_ARITH; end
      OP_SLA: begin ctrl_o = CTRL_SLA; flag_mask_o = MASK_SHIFT; is_shift_o = 1'b1; end
      OP_SLL: begin ctrl_o = CTRL_SLL; flag_mask_o = MASK_SHIFT; is_shift_o = 1'b1; end
      OP_ROL: begin ctrl_o = CTRL_ROL; flag_mask_o = MASK_SHIFT; is_shift_o = 1'b1; end
      OP_SRA: begin ctrl_o = CTRL_SRA; flag_mask_o = MASK_SHIFT; is_shift_o = 1'b1; end
      OP_SRL: begin ctrl_o = CTRL_SRL; flag_mask_o = MASK_SHIFT; is_shift_o = 1'b1; end
      OP_ROR: begin ctrl_o = CTRL_ROR; flag_mask_o = MASK_SHIFT; is_shift_o = 1'b1; end
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts ALU requests, drives ALU2 decoder control lines, sequences multi-pass shifts
// and maintains the {V,S,Z,C} flag register.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_op_i,
  input  logic [3:0] req_cnt_i,
  input  logic       flush_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_we_i,
  input  logic [3:0] flag_wd_i,
  output logic [5:0] ctrl_o,
  output logic       c_flag_o,
  output logic       acc_we_o,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] flags_o
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;

  logic [OP_W-1:0]    enc_op;
  logic [CTRL_W-1:0]  enc_ctrl;
  logic               enc_shift;
  logic               enc_ill;
  logic [FLAGS_W-1:0] enc_mask;
  logic               accept;
  logic               last_pass;

  // One decoder serves both the incoming request (IDLE) and the latched op (busy).
  assign enc_op = (state_q == ST_IDLE) ? req_op_i : op_q;

  alu_op_encode u_encode (
    .op_i         (enc_op),
    .ctrl_o       (enc_ctrl),
    .is_shift_o   (enc_shift),
    .is_illegal_o (enc_ill),
    .flag_mask_o  (enc_mask)
  );

  assign req_ready_o = (state_q == ST_IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;
  assign last_pass   = (cnt_q == CNT_W'(1));
  assign flags_o     = flags_q;
  assign c_flag_o    = flags_q[FLG_C];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (enc_ill)        state_d = ST_ERR;
          else if (enc_shift) state_d = ST_SHIFT;
          else                state_d = ST_EXEC;
        end
      end
      ST_EXEC:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      ST_SHIFT: if (flush_i || last_pass) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A flush in the completing cycle suppresses done_o/err_o.
  always_comb begin
    ctrl_o   = '0;
    acc_we_o = 1'b0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_EXEC: begin
          ctrl_o   = enc_ctrl;
          acc_we_o = 1'b1;
          done_o   = !flush_i;
        end
        ST_SHIFT: begin
          ctrl_o   = enc_ctrl;
          acc_we_o = 1'b1;
          done_o   = last_pass && !flush_i;
        end
        ST_ERR: begin
          done_o = !flush_i;
          err_o  = !flush_i;
        end
        default: ;
      endcase
    end
  end

  // Op/count latch and flag register update.
  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    if (accept) begin
      op_d  = req_op_i;
      cnt_d = (req_cnt_i == '0) ? CNT_W'(1) : req_cnt_i;
    end else if (state_q == ST_SHIFT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (acc_we_o && !flush_i) begin
      flags_d = (flags_q & ~enc_mask) | (alu_flags_i & enc_mask);
      if (op_clears_v(op_q)) flags_d[FLG_V] = 1'b0;
    end else if ((state_q == ST_IDLE) && flag_we_i && !accept) begin
      flags_d = flag_wd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against a pass-level behavioural model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] req_op_i;
  logic [3:0] req_cnt_i;
  logic       flush_i;
  logic [3:0] alu_flags_i;
  logic       flag_we_i;
  logic [3:0] flag_wd_i;
  logic [5:0] ctrl_o;
  logic       c_flag_o;
  logic       acc_we_o;
  logic       done_o;
  logic       err_o;
  logic [3:0] flags_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] model_flags;
  logic [5:0] ctrl_tab [16];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_cnt_i   (req_cnt_i),
    .flush_i     (flush_i),
    .alu_flags_i (alu_flags_i),
    .flag_we_i   (flag_we_i),
    .flag_wd_i   (flag_wd_i),
    .ctrl_o      (ctrl_o),
    .c_flag_o    (c_flag_o),
    .acc_we_o    (acc_we_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .flags_o     (flags_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Table strings are written Ctrl0 first; ctrl_o bit i carries Ctrl i.
  function automatic logic [5:0] exp_ctrl(input logic [3:0] op);
    logic [5:0] s;
    logic [5:0] r;
    s = ctrl_tab[op];
    for (int i = 0; i < 6; i++) r[i] = s[5-i];
    return r;
  endfunction

  function automatic int passes(input logic [3:0] op, input logic [3:0] cnt);
    if (op >= 4'h9 && op <= 4'hE) return (cnt == 4'd0) ? 1 : int'(cnt);
    return 1;
  endfunction

  // Flags as {V,S,Z,C}: bit3=V, bit2=S, bit1=Z, bit0=C.
  function automatic logic [3:0] next_flags(input logic [3:0] op, input logic [3:0] prev,
                                            input logic [3:0] alu);
    logic [3:0] f;
    f = prev;
    if (op == 4'h1 || op == 4'h2 || op == 4'h7 || op == 4'h8) begin
      f = alu;
    end else if (op >= 4'h3 && op <= 4'h6) begin
      f[2] = alu[2];
      f[1] = alu[1];
      f[3] = 1'b0;
    end else if (op >= 4'h9 && op <= 4'hE) begin
      f[2] = alu[2];
      f[1] = alu[1];
      f[0] = alu[0];
    end
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},  32'(ctrl_o),   32'd0);
    check({tag, "_accwe"}, 32'(acc_we_o), 32'd0);
    check({tag, "_done"},  32'(done_o),   32'd0);
    check({tag, "_err"},   32'(err_o),    32'd0);
    check({tag, "_flags"}, 32'(flags_o),  32'd0);
    check({tag, "_cflag"}, 32'(c_flag_o), 32'd0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; mode 0 none, 1 flush, 2 rst at pass abort_at.
  task automatic run_op(input logic [3:0] op, input logic [3:0] cnt,
                        input int mode, input int abort_at);
    int  n;
    bit  abort;
    bit  ill;
    n   = passes(op, cnt);
    ill = (op == 4'hF);
    check("ready_before", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_cnt_i   = cnt;
    flag_we_i   = 1'($urandom_range(0, 1));
    flag_wd_i   = 4'($urandom);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_op_i    = 4'($urandom);
    req_cnt_i   = 4'($urandom);
    for (int p = 1; p <= n; p++) begin
      alu_flags_i = 4'($urandom);
      flag_we_i   = 1'($urandom_range(0, 1));
      flag_wd_i   = 4'($urandom);
      abort = (mode != 0) && (p == abort_at);
      if (abort && mode == 2) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flag_we_i = 1'b0;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        model_flags = 4'h0;
        #1;
        check("ready_after_rst", 32'(req_ready_o), 32'd1);
        return;
      end
      if (abort) flush_i = 1'b1;
      #1;
      if (!abort) begin
        check("ctrl",   32'(ctrl_o),   ill ? 32'd0 : 32'(exp_ctrl(op)));
        check("acc_we", 32'(acc_we_o), ill ? 32'd0 : 32'd1);
      end
      check("done",   32'(done_o),      32'((p == n) && !abort));
      check("err",    32'(err_o),       32'(ill && !abort));
      check("busy",   32'(req_ready_o), 32'd0);
      check("c_flag", 32'(c_flag_o),    32'(model_flags[0]));
      if (!abort && !ill) model_flags = next_flags(op, model_flags, alu_flags_i);
      @(posedge clk);
      @(negedge clk);
      flush_i   = 1'b0;
      flag_we_i = 1'b0;
      if (abort) break;
    end
    check("flags_after", 32'(flags_o),     32'(model_flags));
    check("ready_after", 32'(req_ready_o), 32'd1);
  endtask

  task automatic flag_write(input logic [3:0] wd);
    flag_we_i = 1'b1;
    flag_wd_i = wd;
    @(posedge clk);
    @(negedge clk);
    flag_we_i   = 1'b0;
    model_flags = wd;
    check("flag_wr",   32'(flags_o),  32'(wd));
    check("flag_wr_c", 32'(c_flag_o), 32'(wd[0]));
  endtask

  initial begin
    ctrl_tab[0]  = 6'b000000; ctrl_tab[1]  = 6'b010010; ctrl_tab[2]  = 6'b010001;
    ctrl_tab[3]  = 6'b000110; ctrl_tab[4]  = 6'b001010; ctrl_tab[5]  = 6'b001110;
    ctrl_tab[6]  = 6'b001100; ctrl_tab[7]  = 6'b011011; ctrl_tab[8]  = 6'b011000;
    ctrl_tab[9]  = 6'b100100; ctrl_tab[10] = 6'b100000; ctrl_tab[11] = 6'b100010;
    ctrl_tab[12] = 6'b101100; ctrl_tab[13] = 6'b101000; ctrl_tab[14] = 6'b101010;
    ctrl_tab[15] = 6'b000000;

    rst = 1'b1;
    req_valid_i = 1'b0; req_op_i = '0; req_cnt_i = '0; flush_i = 1'b0;
    alu_flags_i = '0; flag_we_i = 1'b0; flag_wd_i = '0;
    model_flags = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_post_reset", 32'(req_ready_o), 32'd1);
    @(negedge clk);

    run_op(4'h1, 4'd0, 0, 0);
    flag_write(4'b0001);
    run_op(4'h3, 4'd0, 0, 0);
    run_op(4'hB, 4'd3, 0, 0);
    run_op(4'hA, 4'd0, 0, 0);
    run_op(4'hC, 4'd15, 0, 0);
    run_op(4'hF, 4'd5, 0, 0);
    run_op(4'hD, 4'd8, 1, 4);
    run_op(4'hD, 4'd8, 2, 4);
    flag_write(4'b1111);
    run_op(4'hE, 4'd4, 0, 0);
    flag_write(4'b1111);

    for (int t = 0; t < 300; t++) begin
      logic [3:0] op;
      logic [3:0] cnt;
      int r;
      int mode;
      op   = 4'($urandom);
      cnt  = 4'($urandom);
      r    = int'($urandom_range(0, 15));
      mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      run_op(op, cnt, mode, int'($urandom_range(1, passes(op, cnt))));
      if ($urandom_range(0, 7) == 0) flag_write(4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
